// File: rtl/score_display_ctrl.sv
// Score counter (BCD or hex digits) with registered active-low 7-segment outputs,
// leading-zero blanking and whole-display blinking.
module score_display_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int DECIMAL    = 1,
  parameter int SATURATE   = 0,
  parameter int BLINK_HALF = 25000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    inc,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  input  logic                    lz_blank,
  input  logic                    blink_en,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    overflow,
  output logic [7*NUM_DIGITS-1:0] seg
);

  localparam logic [3:0] DIGIT_MAX = (DECIMAL != 0) ? 4'd9 : 4'd15;
  localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_HALF - 1);

  logic [4*NUM_DIGITS-1:0] value_reg, value_next, value_inc, load_clean;
  logic                    overflow_reg, overflow_next;
  logic [7*NUM_DIGITS-1:0] seg_reg, seg_next;
  logic [CW-1:0]           cnt_reg, cnt_next;
  logic                    phase_reg, phase_next;
  logic [NUM_DIGITS:0]     carry;
  logic [NUM_DIGITS:0]     zero_above;
  logic                    blank_all;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'h0: p = 7'b1000000;
      4'h1: p = 7'b1111001;
      4'h2: p = 7'b0100100;
      4'h3: p = 7'b0110000;
      4'h4: p = 7'b0011001;
      4'h5: p = 7'b0010010;
      4'h6: p = 7'b0000010;
      4'h7: p = 7'b1111000;
      4'h8: p = 7'b0000000;
      4'h9: p = 7'b0011000;
      4'hA: p = 7'b0001000;
      4'hB: p = 7'b0000011;
      4'hC: p = 7'b1000110;
      4'hD: p = 7'b0100001;
      4'hE: p = 7'b0000110;
      default: p = 7'b0001110;
    endcase
    return p;
  endfunction

  // carry[NUM_DIGITS] doubles as the "all digits at max" flag.
  assign carry[0]               = 1'b1;
  assign zero_above[NUM_DIGITS] = 1'b1;
  assign blank_all              = blink_en && phase_reg;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [3:0] d;
      logic [3:0] ld;
      logic       lz_hide;
      assign d  = value_reg[4*gi +: 4];
      assign ld = load_val[4*gi +: 4];
      assign value_inc[4*gi +: 4]  = !carry[gi] ? d : ((d == DIGIT_MAX) ? 4'd0 : d + 4'd1);
      assign carry[gi+1]           = carry[gi] && (d == DIGIT_MAX);
      assign load_clean[4*gi +: 4] = ((DECIMAL != 0) && (ld > 4'd9)) ? 4'd9 : ld;
      assign zero_above[gi]        = zero_above[gi+1] && (d == 4'd0);
      // Digit 0 always stays lit so a zero score reads "0".
      assign lz_hide               = (gi != 0) && lz_blank && zero_above[gi];
      assign seg_next[7*gi +: 7]   = (blank_all || lz_hide) ? 7'b1111111 : seg7(d);
    end
  endgenerate

  always_comb begin
    value_next    = value_reg;
    overflow_next = overflow_reg;
    if (clear) begin
      value_next    = '0;
      overflow_next = 1'b0;
    end else if (load) begin
      value_next    = load_clean;
      overflow_next = 1'b0;
    end else if (inc) begin
      if (carry[NUM_DIGITS]) begin
        overflow_next = 1'b1;
        value_next    = (SATURATE != 0) ? value_reg : value_inc;
      end else begin
        value_next = value_inc;
      end
    end
  end

  always_comb begin
    cnt_next   = cnt_reg;
    phase_next = phase_reg;
    if (!blink_en) begin
      cnt_next   = '0;
      phase_next = 1'b0;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_next   = '0;
      phase_next = !phase_reg;
    end else begin
      cnt_next = cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_reg    <= '0;
      overflow_reg <= 1'b0;
      seg_reg      <= '1;
      cnt_reg      <= '0;
      phase_reg    <= 1'b0;
    end else begin
      value_reg    <= value_next;
      overflow_reg <= overflow_next;
      seg_reg      <= seg_next;
      cnt_reg      <= cnt_next;
      phase_reg    <= phase_next;
    end
  end

  assign value    = value_reg;
  assign overflow = overflow_reg;
  assign seg      = seg_reg;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Bench for score_display_ctrl: decimal-wrap, decimal-saturate and hex instances
// share one stimulus stream; vector table plus hand-written display sequences.
module tb_score_display_ctrl;

  logic        clk = 1'b0;
  logic        reset, inc, clear, load, lz_blank, blink_en;
  logic [15:0] load_val;
  logic [15:0] value, sat_value, hex_value;
  logic        overflow, sat_overflow, hex_overflow;
  logic [27:0] seg, sat_seg, hex_seg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  score_display_ctrl #(.NUM_DIGITS(4), .DECIMAL(1), .SATURATE(0), .BLINK_HALF(4)) dut (
    .clk(clk), .reset(reset), .inc(inc), .clear(clear), .load(load), .load_val(load_val),
    .lz_blank(lz_blank), .blink_en(blink_en), .value(value), .overflow(overflow), .seg(seg));

  score_display_ctrl #(.NUM_DIGITS(4), .DECIMAL(1), .SATURATE(1), .BLINK_HALF(4)) dut_sat (
    .clk(clk), .reset(reset), .inc(inc), .clear(clear), .load(load), .load_val(load_val),
    .lz_blank(lz_blank), .blink_en(blink_en), .value(sat_value), .overflow(sat_overflow),
    .seg(sat_seg));

  score_display_ctrl #(.NUM_DIGITS(4), .DECIMAL(0), .SATURATE(0), .BLINK_HALF(4)) dut_hex (
    .clk(clk), .reset(reset), .inc(inc), .clear(clear), .load(load), .load_val(load_val),
    .lz_blank(lz_blank), .blink_en(blink_en), .value(hex_value), .overflow(hex_overflow),
    .seg(hex_seg));

  typedef struct {
    logic        clr, ld, inc, lz;
    logic [15:0] lv;
    logic [15:0] ev;
    logic        eo;
    logic [15:0] sv;
    logic        so;
    logic [15:0] hv;
  } vec_t;

  vec_t vecs[16];
  vec_t sb[$];

  localparam logic [27:0] ALL_OFF = 28'hFFFFFFF;

  function automatic logic [6:0] pat(input logic [3:0] d);
    case (d)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0011000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [27:0] enc(input logic [15:0] v, input logic lz);
    logic [27:0] r;
    logic        still_zero;
    r = '1;
    still_zero = 1'b1;
    for (int k = 3; k >= 0; k--) begin
      if (lz && still_zero && (k > 0) && (v[4*k +: 4] == 4'd0)) begin
        r[7*k +: 7] = 7'b1111111;
      end else begin
        r[7*k +: 7] = pat(v[4*k +: 4]);
        still_zero = 1'b0;
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inc = 1'b0; clear = 1'b0; load = 1'b0; load_val = 16'h0000;
  endtask

  initial begin
    vec_t        e;
    logic [15:0] prev_val;
    logic [27:0] vis5;

    //          clr ld  inc lz  load_val  ev       eo   sv       so   hv
    vecs[0]  = '{1'b0,1'b1,1'b0,1'b0,16'h0199,16'h0199,1'b0,16'h0199,1'b0,16'h0199};
    vecs[1]  = '{1'b0,1'b0,1'b1,1'b0,16'h0000,16'h0200,1'b0,16'h0200,1'b0,16'h019A};
    vecs[2]  = '{1'b0,1'b1,1'b0,1'b1,16'h9999,16'h9999,1'b0,16'h9999,1'b0,16'h9999};
    vecs[3]  = '{1'b0,1'b0,1'b1,1'b0,16'h0000,16'h0000,1'b1,16'h9999,1'b1,16'h999A};
    vecs[4]  = '{1'b0,1'b0,1'b1,1'b1,16'h0000,16'h0001,1'b1,16'h9999,1'b1,16'h999B};
    vecs[5]  = '{1'b1,1'b0,1'b0,1'b0,16'h0000,16'h0000,1'b0,16'h0000,1'b0,16'h0000};
    vecs[6]  = '{1'b0,1'b1,1'b0,1'b1,16'h12AF,16'h1299,1'b0,16'h1299,1'b0,16'h12AF};
    vecs[7]  = '{1'b0,1'b0,1'b1,1'b0,16'h0000,16'h1300,1'b0,16'h1300,1'b0,16'h12B0};
    vecs[8]  = '{1'b0,1'b1,1'b0,1'b0,16'h0042,16'h0042,1'b0,16'h0042,1'b0,16'h0042};
    vecs[9]  = '{1'b1,1'b1,1'b1,1'b1,16'h0077,16'h0000,1'b0,16'h0000,1'b0,16'h0000};
    vecs[10] = '{1'b0,1'b1,1'b1,1'b1,16'h0007,16'h0007,1'b0,16'h0007,1'b0,16'h0007};
    vecs[11] = '{1'b0,1'b0,1'b1,1'b1,16'h0000,16'h0008,1'b0,16'h0008,1'b0,16'h0008};
    vecs[12] = '{1'b0,1'b1,1'b0,1'b0,16'h0999,16'h0999,1'b0,16'h0999,1'b0,16'h0999};
    vecs[13] = '{1'b0,1'b0,1'b1,1'b1,16'h0000,16'h1000,1'b0,16'h1000,1'b0,16'h099A};
    vecs[14] = '{1'b0,1'b1,1'b0,1'b0,16'hFFFF,16'h9999,1'b0,16'h9999,1'b0,16'hFFFF};
    vecs[15] = '{1'b0,1'b0,1'b1,1'b0,16'h0000,16'h0000,1'b1,16'h9999,1'b1,16'h0000};

    reset = 1'b1; lz_blank = 1'b0; blink_en = 1'b0;
    idle_inputs();

    // Reset state
    step();
    chk("reset_value", {16'h0, value}, 32'h0);
    chk("reset_overflow", {31'h0, overflow}, 32'h0);
    chk("reset_seg", {4'h0, seg}, {4'h0, ALL_OFF});
    @(negedge clk);
    reset = 1'b0;
    step();
    step();
    chk("post_reset_seg", {4'h0, seg}, {4'h0, {4{7'b1000000}}});

    // Vector table through the scoreboard
    prev_val = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      clear = vecs[i].clr; load = vecs[i].ld; inc = vecs[i].inc;
      lz_blank = vecs[i].lz; load_val = vecs[i].lv;
      sb.push_back(vecs[i]);
      step();
      e = sb.pop_front();
      chk($sformatf("vec%0d_value", i), {16'h0, value}, {16'h0, e.ev});
      chk($sformatf("vec%0d_overflow", i), {31'h0, overflow}, {31'h0, e.eo});
      chk($sformatf("vec%0d_sat_value", i), {16'h0, sat_value}, {16'h0, e.sv});
      chk($sformatf("vec%0d_sat_overflow", i), {31'h0, sat_overflow}, {31'h0, e.so});
      chk($sformatf("vec%0d_hex_value", i), {16'h0, hex_value}, {16'h0, e.hv});
      chk($sformatf("vec%0d_seg", i), {4'h0, seg}, {4'h0, enc(prev_val, e.lz)});
      prev_val = e.ev;
    end
    idle_inputs();
    lz_blank = 1'b0;

    // 0199 + 1 -> 0200 and its digit patterns, then leading-zero blanking
    load = 1'b1; load_val = 16'h0199; step();
    load = 1'b0; inc = 1'b1; step();
    inc = 1'b0; step();
    chk("c2_value", {16'h0, value}, 32'h0200);
    chk("c2_seg", {4'h0, seg}, {4'h0, 7'b1000000, 7'b0100100, 7'b1000000, 7'b1000000});
    lz_blank = 1'b1; step();
    chk("c2_seg_lz", {4'h0, seg}, {4'h0, 7'b1111111, 7'b0100100, 7'b1000000, 7'b1000000});
    lz_blank = 1'b0;

    // Hex instance: 12AF + 1 -> 12B0 with letter digit on display
    load = 1'b1; load_val = 16'h12AF; step();
    load = 1'b0; inc = 1'b1; step();
    inc = 1'b0; step();
    chk("c4_hex_value", {16'h0, hex_value}, 32'h12B0);
    chk("c4_hex_seg_d1d0", {18'h0, hex_seg[13:0]}, {18'h0, 7'b0000011, 7'b1000000});

    // Blinking with value 0005: visible 4 updates, blank 4 updates, ...
    vis5 = {7'b1000000, 7'b1000000, 7'b1000000, 7'b0010010};
    load = 1'b1; load_val = 16'h0005; step();
    load = 1'b0; blink_en = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      step();
      chk($sformatf("blink_%0d", k), {4'h0, seg},
          {4'h0, ((((k - 1) / 4) % 2) == 1) ? ALL_OFF : vis5});
    end
    blink_en = 1'b0; step();
    chk("blink_drop_visible", {4'h0, seg}, {4'h0, vis5});
    chk("blink_value_kept", {16'h0, value}, 32'h0005);

    // Reset mid-operation is immediate, then a fresh start
    load = 1'b1; load_val = 16'h9999; step();
    load = 1'b0; inc = 1'b1; step();
    inc = 1'b0; step();
    chk("pre_reset_overflow", {31'h0, overflow}, 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_value", {16'h0, value}, 32'h0);
    chk("async_reset_overflow", {31'h0, overflow}, 32'h0);
    chk("async_reset_seg", {4'h0, seg}, {4'h0, ALL_OFF});
    @(negedge clk);
    reset = 1'b0; inc = 1'b1;
    step();
    inc = 1'b0;
    chk("fresh_start_value", {16'h0, value}, 32'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
